// File: rtl/capture_controller.sv
// Logic analyzer capture controller: command execution, triggered capture
// into sample RAM, and newest-first readout / device ID to the UART TX.
module capture_controller #(
    parameter int ADDR_WIDTH = 12,
    parameter int DIV_WIDTH  = 24
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  cmd_recieved,
    input  logic [7:0]            opcode,
    input  logic [31:0]           command,
    input  logic [7:0]            sample_in,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [7:0]            mem_wdata,
    input  logic [7:0]            mem_rdata,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  tx_ready,
    output logic                  armed,
    output logic                  triggered,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND_ID,
        S_ARMED,
        S_TRIGGERED,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_RD_SEND
    } state_t;

    localparam logic [7:0] OP_RESET = 8'h00;
    localparam logic [7:0] OP_ARM   = 8'h01;
    localparam logic [7:0] OP_ID    = 8'h02;
    localparam logic [7:0] OP_MASK  = 8'hC0;
    localparam logic [7:0] OP_VALUE = 8'hC1;
    localparam logic [7:0] OP_DIV   = 8'h80;
    localparam logic [7:0] OP_CNT   = 8'h81;

    state_t                r_state;
    logic [7:0]            r_trig_mask;
    logic [7:0]            r_trig_value;
    logic [DIV_WIDTH-1:0]  r_divider;
    logic [DIV_WIDTH-1:0]  r_div_cnt;
    logic [15:0]           r_read_count;
    logic [15:0]           r_delay_count;
    logic [15:0]           r_dly_cnt;
    logic [15:0]           r_rd_left;
    logic [ADDR_WIDTH-1:0] r_wr_ptr;
    logic [ADDR_WIDTH-1:0] r_rd_ptr;
    logic [1:0]            r_id_idx;
    logic [7:0]            r_tx_data;
    logic                  r_tx_valid;

    logic        w_tick;
    logic        w_capture;
    logic        w_we;
    logic        w_match;
    logic        w_reset_cmd;
    logic [15:0] w_dly_next;
    logic [7:0]  w_id_byte;

    assign w_tick      = (r_div_cnt == r_divider);
    assign w_capture   = (r_state == S_ARMED) || (r_state == S_TRIGGERED);
    assign w_we        = w_capture && w_tick;
    assign w_match     = ((sample_in ^ r_trig_value) & r_trig_mask) == 8'h00;
    assign w_reset_cmd = cmd_recieved && (opcode == OP_RESET);
    assign w_dly_next  = r_dly_cnt + 16'd1;

    always_comb begin
        w_id_byte = 8'h31;
        case (r_id_idx)
            2'd0:    w_id_byte = 8'h31;
            2'd1:    w_id_byte = 8'h41;
            2'd2:    w_id_byte = 8'h4C;
            default: w_id_byte = 8'h53;
        endcase
    end

    // Capture and readout share one RAM port.
    assign mem_we    = w_we;
    assign mem_addr  = w_capture ? r_wr_ptr : r_rd_ptr;
    assign mem_wdata = w_we ? sample_in : 8'h00;
    assign tx_data   = r_tx_data;
    assign tx_valid  = r_tx_valid;
    assign armed     = (r_state == S_ARMED);
    assign triggered = (r_state == S_TRIGGERED);
    assign busy      = (r_state != S_IDLE);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= S_IDLE;
            r_trig_mask   <= '0;
            r_trig_value  <= '0;
            r_divider     <= '0;
            r_div_cnt     <= '0;
            r_read_count  <= '0;
            r_delay_count <= '0;
            r_dly_cnt     <= '0;
            r_rd_left     <= '0;
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_id_idx      <= '0;
            r_tx_data     <= '0;
            r_tx_valid    <= 1'b0;
        end else begin
            r_div_cnt <= w_tick ? '0 : r_div_cnt + 1'b1;
            if (w_we) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_reset_cmd) begin
                r_state    <= S_IDLE;
                r_tx_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (cmd_recieved) begin
                            case (opcode)
                                OP_ARM: begin
                                    r_wr_ptr  <= '0;
                                    r_div_cnt <= '0;
                                    r_dly_cnt <= '0;
                                    r_state   <= S_ARMED;
                                end
                                OP_ID: begin
                                    r_id_idx   <= 2'd0;
                                    r_tx_data  <= 8'h31;
                                    r_tx_valid <= 1'b1;
                                    r_state    <= S_SEND_ID;
                                end
                                OP_MASK:  r_trig_mask  <= command[7:0];
                                OP_VALUE: r_trig_value <= command[7:0];
                                OP_DIV:   r_divider    <= command[DIV_WIDTH-1:0];
                                OP_CNT: begin
                                    r_read_count  <= command[31:16];
                                    r_delay_count <= command[15:0];
                                end
                                default: ;
                            endcase
                        end
                    end
                    S_SEND_ID: begin
                        if (r_tx_valid) begin
                            if (tx_ready) begin
                                r_tx_valid <= 1'b0;
                                if (r_id_idx == 2'd3) begin
                                    r_state <= S_IDLE;
                                end else begin
                                    r_id_idx <= r_id_idx + 2'd1;
                                end
                            end
                        end else begin
                            r_tx_data  <= w_id_byte;
                            r_tx_valid <= 1'b1;
                        end
                    end
                    S_ARMED: begin
                        if (w_tick && w_match) begin
                            if (r_delay_count == 16'd0) begin
                                r_rd_ptr  <= r_wr_ptr;
                                r_rd_left <= r_read_count;
                                r_state   <= S_RD_ISSUE;
                            end else begin
                                r_state <= S_TRIGGERED;
                            end
                        end
                    end
                    S_TRIGGERED: begin
                        if (w_tick) begin
                            r_dly_cnt <= w_dly_next;
                            if (w_dly_next == r_delay_count) begin
                                r_rd_ptr  <= r_wr_ptr;
                                r_rd_left <= r_read_count;
                                r_state   <= S_RD_ISSUE;
                            end
                        end
                    end
                    S_RD_ISSUE: begin
                        r_state <= (r_rd_left == 16'd0) ? S_IDLE : S_RD_WAIT;
                    end
                    S_RD_WAIT: begin
                        r_tx_data  <= mem_rdata;
                        r_tx_valid <= 1'b1;
                        r_state    <= S_RD_SEND;
                    end
                    S_RD_SEND: begin
                        if (tx_ready) begin
                            r_tx_valid <= 1'b0;
                            r_rd_ptr   <= r_rd_ptr - 1'b1;
                            r_rd_left  <= r_rd_left - 16'd1;
                            r_state    <= S_RD_ISSUE;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_capture_controller.sv
// Bench for capture_controller: table-driven capture scenarios scored
// against a TX byte queue, plus hand sequences for ID, reset and timing.
module tb_capture_controller;

    localparam int AW = 4;
    localparam int DW = 24;

    logic          clock = 1'b0;
    logic          reset;
    logic          cmd_recieved;
    logic [7:0]    opcode;
    logic [31:0]   command;
    logic [7:0]    sample_in;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [7:0]    mem_wdata;
    logic [7:0]    mem_rdata;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          tx_ready;
    logic          armed;
    logic          triggered;
    logic          busy;

    capture_controller #(.ADDR_WIDTH(AW), .DIV_WIDTH(DW)) dut (
        .clock(clock), .reset(reset),
        .cmd_recieved(cmd_recieved), .opcode(opcode), .command(command),
        .sample_in(sample_in),
        .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata),
        .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
        .armed(armed), .triggered(triggered), .busy(busy)
    );

    always #5 clock = ~clock;

    logic [7:0] ram [2**AW];
    always @(posedge clock) begin
        if (mem_we) ram[mem_addr] <= mem_wdata;
        mem_rdata <= ram[mem_addr];
    end

    typedef struct packed {
        logic [7:0]  mask;
        logic [7:0]  value;
        logic [23:0] div;
        logic [15:0] dly;
        logic [15:0] rc;
        logic [7:0]  base;
        logic [39:0] exp;
    } vec_t;

    int         n_err = 0;
    int         n_checks = 0;
    logic [7:0] sb [$];
    logic       pv = 1'b0;
    logic       pr = 1'b0;
    logic       prc = 1'b0;
    logic [7:0] pd = 8'h00;
    logic       ramp_on = 1'b0;

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One clock: TX monitor / scoreboard at the falling edge, then advance.
    task automatic step();
        logic [7:0] e;
        @(negedge clock);
        if (reset) begin
            if (pv && !pr && !prc) begin
                chk("tx_hold_valid", 32'(tx_valid), 32'd1);
                chk("tx_hold_data", 32'(tx_data), 32'(pd));
            end
            if (pv && pr) chk("tx_drop_after_accept", 32'(tx_valid), 32'd0);
            if (tx_valid && tx_ready) begin
                if (sb.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL tx_unexpected: got %0h expected none", tx_data);
                end else begin
                    e = sb.pop_front();
                    chk("tx_byte", 32'(tx_data), 32'(e));
                end
            end
        end
        pv  = reset && tx_valid;
        pr  = tx_ready;
        pd  = tx_data;
        prc = cmd_recieved && (opcode == 8'h00);
        @(posedge clock);
        #1;
        if (ramp_on) sample_in = sample_in + 8'd1;
    endtask

    task automatic send_cmd(logic [7:0] op, logic [31:0] arg);
        cmd_recieved = 1'b1;
        opcode       = op;
        command      = arg;
        step();
        cmd_recieved = 1'b0;
        opcode       = 8'h00;
        command      = 32'h0;
    endtask

    task automatic configure(logic [7:0] m, logic [7:0] v, logic [23:0] d,
                             logic [15:0] dly, logic [15:0] rc);
        send_cmd(8'hC0, {24'h0, m});
        send_cmd(8'hC1, {24'h0, v});
        send_cmd(8'h80, {8'h0, d});
        send_cmd(8'h81, {rc, dly});
    endtask

    task automatic wait_idle(int budget, string name);
        int n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        chk(name, 32'(busy), 32'd0);
    endtask

    task automatic run_vec(vec_t v, int idx);
        configure(v.mask, v.value, v.div, v.dly, v.rc);
        for (int i = 0; i < int'(v.rc) && i < 5; i++)
            sb.push_back(v.exp[8*(4-i) +: 8]);
        tx_ready = 1'b1;
        send_cmd(8'h01, 32'h0);
        sample_in = v.base;
        ramp_on   = 1'b1;
        wait_idle(600, $sformatf("vec%0d_idle", idx));
        ramp_on = 1'b0;
        chk($sformatf("vec%0d_drained", idx), 32'(sb.size()), 32'd0);
        sb.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs [5];
        int   n;
        vecs[0] = '{mask: 8'hFF, value: 8'hA5, div: 24'd0, dly: 16'd2,
                    rc: 16'd4, base: 8'hA2, exp: 40'hA7A6A5A400};
        vecs[1] = '{mask: 8'h00, value: 8'h00, div: 24'd3, dly: 16'd0,
                    rc: 16'd1, base: 8'h10, exp: 40'h1300000000};
        vecs[2] = '{mask: 8'hFF, value: 8'h07, div: 24'd0, dly: 16'd20,
                    rc: 16'd3, base: 8'h00, exp: 40'h1B1A190000};
        vecs[3] = '{mask: 8'hF0, value: 8'h30, div: 24'd1, dly: 16'd3,
                    rc: 16'd5, base: 8'h20, exp: 40'h373533312F};
        vecs[4] = '{mask: 8'hFF, value: 8'h45, div: 24'd2, dly: 16'd1,
                    rc: 16'd0, base: 8'h40, exp: 40'h0};

        reset        = 1'b0;
        cmd_recieved = 1'b0;
        opcode       = 8'h00;
        command      = 32'h0;
        sample_in    = 8'h5A;
        tx_ready     = 1'b1;
        #2;
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_addr", 32'(mem_addr), 32'd0);
        chk("rst_mem_wdata", 32'(mem_wdata), 32'd0);
        chk("rst_tx_valid", 32'(tx_valid), 32'd0);
        chk("rst_tx_data", 32'(tx_data), 32'd0);
        chk("rst_armed", 32'(armed), 32'd0);
        chk("rst_triggered", 32'(triggered), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        reset     = 1'b1;
        sample_in = 8'h00;
        step();

        // ID with the transmitter always ready.
        sb.push_back(8'h31); sb.push_back(8'h41);
        sb.push_back(8'h4C); sb.push_back(8'h53);
        send_cmd(8'h02, 32'h0);
        chk("id_busy", 32'(busy), 32'd1);
        wait_idle(50, "id_idle");
        chk("id_drained", 32'(sb.size()), 32'd0);

        // ID with back-pressure on the second byte.
        sb.push_back(8'h31); sb.push_back(8'h41);
        sb.push_back(8'h4C); sb.push_back(8'h53);
        tx_ready = 1'b0;
        send_cmd(8'h02, 32'h0);
        tx_ready = 1'b1;
        step();
        tx_ready = 1'b0;
        step();
        for (int i = 0; i < 5; i++) begin
            chk("id_stall_valid", 32'(tx_valid), 32'd1);
            chk("id_stall_data", 32'(tx_data), 32'h41);
            step();
        end
        tx_ready = 1'b1;
        wait_idle(50, "id2_idle");
        chk("id2_drained", 32'(sb.size()), 32'd0);

        for (int i = 0; i < 5; i++) run_vec(vecs[i], i);

        // Divider spacing with a trigger that never fires; config while armed.
        configure(8'hFF, 8'h01, 24'd3, 16'd0, 16'd0);
        send_cmd(8'h01, 32'h0);
        for (int k = 0; k < 12; k++) begin
            sample_in = 8'h80 | 8'(k);
            #2;
            chk($sformatf("div_we_k%0d", k), 32'(mem_we), 32'((k % 4) == 3));
            if ((k % 4) == 3) begin
                chk("div_addr", 32'(mem_addr), 32'(k / 4));
                chk("div_wdata", 32'(mem_wdata), 32'(8'h80 | 8'(k)));
            end
            step();
        end
        send_cmd(8'hC0, 32'h0);
        for (int k = 0; k < 8; k++) step();
        chk("cfg_ignored_armed", 32'(armed), 32'd1);
        chk("cfg_ignored_trig", 32'(triggered), 32'd0);
        send_cmd(8'h00, 32'h0);
        chk("reset_cmd_busy", 32'(busy), 32'd0);
        chk("reset_cmd_armed", 32'(armed), 32'd0);

        // RESET while a readout byte is being accepted.
        configure(8'h00, 8'h00, 24'd0, 16'd0, 16'd4);
        sb.push_back(8'h60);
        tx_ready = 1'b0;
        send_cmd(8'h01, 32'h0);
        sample_in = 8'h60;
        ramp_on   = 1'b1;
        n = 0;
        while (!tx_valid && n < 50) begin
            step();
            n++;
        end
        ramp_on = 1'b0;
        chk("rd_first_valid", 32'(tx_valid), 32'd1);
        tx_ready = 1'b1;
        send_cmd(8'h00, 32'h0);
        chk("rd_reset_valid", 32'(tx_valid), 32'd0);
        chk("rd_reset_busy", 32'(busy), 32'd0);
        chk("rd_reset_sent", 32'(sb.size()), 32'd0);
        step();
        chk("rd_reset_quiet", 32'(tx_valid), 32'd0);
        sb.push_back(8'h31); sb.push_back(8'h41);
        sb.push_back(8'h4C); sb.push_back(8'h53);
        send_cmd(8'h02, 32'h0);
        wait_idle(50, "id3_idle");
        chk("id3_drained", 32'(sb.size()), 32'd0);

        // Asynchronous reset mid-capture clears outputs and config.
        configure(8'hFF, 8'hEE, 24'd0, 16'd5, 16'd2);
        send_cmd(8'h01, 32'h0);
        sample_in = 8'h33;
        step();
        step();
        chk("async_pre_armed", 32'(armed), 32'd1);
        chk("async_pre_we", 32'(mem_we), 32'd1);
        #2;
        reset = 1'b0;
        #1;
        chk("async_we", 32'(mem_we), 32'd0);
        chk("async_wdata", 32'(mem_wdata), 32'd0);
        chk("async_addr", 32'(mem_addr), 32'd0);
        chk("async_armed", 32'(armed), 32'd0);
        chk("async_busy", 32'(busy), 32'd0);
        chk("async_tx_valid", 32'(tx_valid), 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;
        pv    = 1'b0;
        send_cmd(8'h01, 32'h0);
        chk("post_rst_armed", 32'(armed), 32'd1);
        chk("post_rst_we", 32'(mem_we), 32'd1);
        step();
        chk("post_rst_rd_busy", 32'(busy), 32'd1);
        chk("post_rst_rd_armed", 32'(armed), 32'd0);
        chk("post_rst_rd_trig", 32'(triggered), 32'd0);
        step();
        chk("post_rst_idle", 32'(busy), 32'd0);
        chk("post_rst_no_tx", 32'(tx_valid), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
